// File: rtl/apb_slave_responder.sv
// APB completer (no PREADY/PSLVERR): word-addressed memory behind a setup/enable
// phase tracker that reports protocol and address errors and counts good transfers.
module apb_slave_responder #(
   parameter int          SLAVE_ID  = 0,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DEPTH     = 256
) (
   input  logic        Pclk,
   input  logic        Preset,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        err_valid,
   output logic [2:0]  err_code,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count
);

   localparam int          LP_AW   = $clog2(DEPTH);
   localparam logic [31:0] LP_SPAN = 32'(DEPTH) << 2;

   localparam logic [2:0] LP_ERR_NONE      = 3'd0;
   localparam logic [2:0] LP_ERR_EN_NO_SET = 3'd1;
   localparam logic [2:0] LP_ERR_SETUP     = 3'd2;
   localparam logic [2:0] LP_ERR_PHASE     = 3'd3;
   localparam logic [2:0] LP_ERR_RANGE     = 3'd4;
   localparam logic [2:0] LP_ERR_MISALIGN  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_addr;
   logic              r_write;
   logic [31:0]       r_prdata;
   logic              r_err_valid;
   logic [2:0]        r_err_code;
   logic [15:0]       r_wr_count;
   logic [15:0]       r_rd_count;
   logic [31:0]       r_mem [DEPTH];

   logic              w_sel;
   logic [31:0]       w_off;
   logic              w_in_range;
   logic              w_aligned;
   logic              w_good;
   logic [LP_AW-1:0]  w_index;
   logic [2:0]        w_bad_code;
   logic              w_latch;
   logic              w_rd_load;
   logic              w_mem_we;
   logic              w_wr_inc;
   logic              w_rd_inc;
   logic              w_err;
   logic [2:0]        w_err_code_nxt;
   logic              w_unused;

   assign w_sel      = Pselx[SLAVE_ID];
   assign w_off      = Paddr - BASE_ADDR;
   assign w_in_range = (Paddr >= BASE_ADDR) && (w_off < LP_SPAN);
   assign w_aligned  = (Paddr[1:0] == 2'b00);
   assign w_good     = w_in_range && w_aligned;
   assign w_index    = w_off[2 +: LP_AW];
   // A misaligned address is reported as such even when it is also out of range.
   assign w_bad_code = w_aligned ? LP_ERR_RANGE : LP_ERR_MISALIGN;
   assign w_unused   = ^{Pselx, w_off};

   // Next-state and per-edge control decode of the setup/enable phase tracker
   always_comb begin
      w_state_nxt    = r_state;
      w_latch        = 1'b0;
      w_rd_load      = 1'b0;
      w_mem_we       = 1'b0;
      w_wr_inc       = 1'b0;
      w_rd_inc       = 1'b0;
      w_err          = 1'b0;
      w_err_code_nxt = LP_ERR_NONE;
      case (r_state)
         ST_IDLE, ST_ACCESS: begin
            if (w_sel && !Penable) begin
               w_state_nxt = ST_SETUP;
               w_latch     = 1'b1;
               w_rd_load   = !Pwrite;
            end else if (w_sel && Penable) begin
               w_state_nxt    = ST_IDLE;
               w_err          = 1'b1;
               w_err_code_nxt = LP_ERR_EN_NO_SET;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (w_sel && Penable) begin
               if ((Paddr != r_addr) || (Pwrite != r_write)) begin
                  w_state_nxt    = ST_IDLE;
                  w_err          = 1'b1;
                  w_err_code_nxt = LP_ERR_PHASE;
               end else begin
                  w_state_nxt = ST_ACCESS;
                  if (!w_good) begin
                     w_err          = 1'b1;
                     w_err_code_nxt = w_bad_code;
                  end else if (Pwrite) begin
                     w_mem_we = 1'b1;
                     w_wr_inc = 1'b1;
                  end else begin
                     w_rd_inc = 1'b1;
                  end
               end
            end else if (w_sel) begin
               // Stretched setup: treated as a fresh setup phase.
               w_state_nxt    = ST_SETUP;
               w_latch        = 1'b1;
               w_rd_load      = !Pwrite;
               w_err          = 1'b1;
               w_err_code_nxt = LP_ERR_SETUP;
            end else begin
               w_state_nxt    = ST_IDLE;
               w_err          = 1'b1;
               w_err_code_nxt = LP_ERR_SETUP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register and setup-phase address/direction capture
   always_ff @(posedge Pclk) begin
      if (Preset) begin
         r_state <= ST_IDLE;
         r_addr  <= 32'd0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_addr  <= Paddr;
            r_write <= Pwrite;
         end
      end
   end

   // Storage array; never reset so contents survive Preset
   always_ff @(posedge Pclk) begin
      if (w_mem_we && !Preset) begin
         r_mem[w_index] <= Pwdata;
      end
   end

   // Read data loads at the setup edge so it is stable for the whole enable cycle
   always_ff @(posedge Pclk) begin
      if (Preset) begin
         r_prdata <= 32'd0;
      end else if (w_rd_load) begin
         r_prdata <= w_good ? r_mem[w_index] : 32'd0;
      end
   end

   // Error pulse and sticky error code
   always_ff @(posedge Pclk) begin
      if (Preset) begin
         r_err_valid <= 1'b0;
         r_err_code  <= LP_ERR_NONE;
      end else begin
         r_err_valid <= w_err;
         if (w_err) begin
            r_err_code <= w_err_code_nxt;
         end
      end
   end

   // Good-transfer counters, wrapping silently
   always_ff @(posedge Pclk) begin
      if (Preset) begin
         r_wr_count <= 16'd0;
         r_rd_count <= 16'd0;
      end else begin
         if (w_wr_inc) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
         if (w_rd_inc) begin
            r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

   assign Prdata    = r_prdata;
   assign err_valid = r_err_valid;
   assign err_code  = r_err_code;
   assign wr_count  = r_wr_count;
   assign rd_count  = r_rd_count;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Self-checking bench for apb_slave_responder: directed protocol scenarios plus
// randomized transfers against a transaction-level reference model.
module tb_apb_slave_responder;

   localparam int          SID   = 1;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 64;
   localparam logic [31:0] SPAN  = 32'(DEPTH) * 32'd4;
   localparam logic [2:0]  SEL   = 3'(1 << SID);

   logic        Pclk = 1'b0;
   logic        Preset = 1'b1;
   logic [2:0]  Pselx = 3'b000;
   logic        Penable = 1'b0;
   logic        Pwrite = 1'b0;
   logic [31:0] Paddr = 32'd0;
   logic [31:0] Pwdata = 32'd0;
   logic [31:0] Prdata;
   logic        err_valid;
   logic [2:0]  err_code;
   logic [15:0] wr_count;
   logic [15:0] rd_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_mem [int];
   logic [15:0] m_wr = 16'd0;
   logic [15:0] m_rd = 16'd0;
   logic [31:0] m_prdata = 32'd0;
   logic [2:0]  m_code = 3'd0;

   apb_slave_responder #(.SLAVE_ID(SID), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .Pclk(Pclk), .Preset(Preset), .Pselx(Pselx), .Penable(Penable),
      .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
      .err_valid(err_valid), .err_code(err_code),
      .wr_count(wr_count), .rd_count(rd_count)
   );

   always #5 Pclk = ~Pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit m_good(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + SPAN) && ((a % 4) == 0);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   // Transaction-level model: returns whether an error pulse is expected.
   task automatic model_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                             output logic exp_err);
      if (!w) m_prdata = m_good(a) ? m_mem[m_idx(a)] : 32'd0;
      exp_err = !m_good(a);
      if (m_good(a)) begin
         if (w) begin
            m_mem[m_idx(a)] = d;
            m_wr = m_wr + 16'd1;
         end else begin
            m_rd = m_rd + 16'd1;
         end
      end else begin
         m_code = ((a % 4) != 0) ? 3'd5 : 3'd4;
      end
   endtask

   // Drives one setup+enable transfer starting at a negedge, ends at a negedge.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd_obs, output logic e_setup, output logic e_en);
      Pselx = SEL; Penable = 1'b0; Pwrite = w; Paddr = a; Pwdata = d;
      @(posedge Pclk); @(negedge Pclk);
      rd_obs  = Prdata;
      e_setup = err_valid;
      Penable = 1'b1;
      @(posedge Pclk); @(negedge Pclk);
      e_en = err_valid;
   endtask

   task automatic idle(input int n, input logic [2:0] sel_val);
      Pselx = sel_val; Penable = 1'b0;
      repeat (n) begin @(posedge Pclk); @(negedge Pclk); end
   endtask

   task automatic test_reset();
      Preset = 1'b1;
      repeat (2) @(posedge Pclk);
      @(negedge Pclk);
      Preset = 1'b0;
      n_checks++; if (Prdata !== 32'd0) begin n_fail++; $display("FAIL reset Prdata: got %h want 0", Prdata); end
      n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset err_valid: got %b want 0", err_valid); end
      n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset err_code: got %0d want 0", err_code); end
      n_checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin n_fail++; $display("FAIL reset counters: got wr=%0d rd=%0d want 0 0", wr_count, rd_count); end
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic e1, e2, ee;
      xfer(BASE + 32'h10, 1'b1, 32'hA5A5_0001, rd, e1, e2); model_xfer(BASE + 32'h10, 1'b1, 32'hA5A5_0001, ee);
      xfer(BASE + 32'h10, 1'b0, 32'd0, rd, e1, e2);         model_xfer(BASE + 32'h10, 1'b0, 32'd0, ee);
      idle(1, 3'b000);
      n_checks++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_rd data: got %h want a5a50001", rd); end
      n_checks++; if (wr_count !== 16'd1 || rd_count !== 16'd1) begin n_fail++; $display("FAIL wr_rd counts: got wr=%0d rd=%0d want 1 1", wr_count, rd_count); end
      n_checks++; if (Prdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_rd hold: got %h want a5a50001", Prdata); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic e1, e2, ee, any_err;
      logic [31:0] v [4];
      time t0;
      any_err = 1'b0;
      for (int i = 0; i < 4; i++) v[i] = $urandom;
      t0 = $time;
      for (int i = 0; i < 3; i++) begin
         xfer(BASE + 32'(4 * i), 1'b1, v[i], rd, e1, e2); model_xfer(BASE + 32'(4 * i), 1'b1, v[i], ee);
         any_err = any_err | e1 | e2;
      end
      for (int i = 0; i < 3; i++) begin
         xfer(BASE + 32'(4 * i), 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + 32'(4 * i), 1'b0, 32'd0, ee);
         any_err = any_err | e1 | e2;
         n_checks++; if (rd !== v[i]) begin n_fail++; $display("FAIL b2b read %0d: got %h want %h", i, rd, v[i]); end
      end
      n_checks++; if (($time - t0) !== 64'd120) begin n_fail++; $display("FAIL b2b timing: got %0t want 120", $time - t0); end
      xfer(BASE + 32'hC, 1'b1, v[3], rd, e1, e2); model_xfer(BASE + 32'hC, 1'b1, v[3], ee);
      xfer(BASE + 32'hC, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + 32'hC, 1'b0, 32'd0, ee);
      any_err = any_err | e1 | e2;
      n_checks++; if (rd !== v[3]) begin n_fail++; $display("FAIL b2b raw: got %h want %h", rd, v[3]); end
      n_checks++; if (any_err !== 1'b0) begin n_fail++; $display("FAIL b2b err_valid: got %b want 0", any_err); end
      n_checks++; if (wr_count !== m_wr || rd_count !== m_rd) begin n_fail++; $display("FAIL b2b counts: got wr=%0d rd=%0d want %0d %0d", wr_count, rd_count, m_wr, m_rd); end
      idle(1, 3'b000);
   endtask

   task automatic test_enable_without_setup();
      logic [31:0] rd, old; logic e1, e2, ee;
      old = $urandom;
      xfer(BASE + 32'h40, 1'b1, old, rd, e1, e2); model_xfer(BASE + 32'h40, 1'b1, old, ee);
      idle(1, 3'b000);
      Pselx = SEL; Penable = 1'b1; Pwrite = 1'b1; Paddr = BASE + 32'h40; Pwdata = ~old;
      @(posedge Pclk); @(negedge Pclk);
      m_code = 3'd1;
      n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin n_fail++; $display("FAIL en_no_setup: got v=%b code=%0d want 1 1", err_valid, err_code); end
      idle(1, 3'b000);
      n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL en_no_setup pulse width: got %b want 0", err_valid); end
      n_checks++; if (wr_count !== m_wr || rd_count !== m_rd) begin n_fail++; $display("FAIL en_no_setup counts: got wr=%0d rd=%0d want %0d %0d", wr_count, rd_count, m_wr, m_rd); end
      xfer(BASE + 32'h40, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + 32'h40, 1'b0, 32'd0, ee);
      n_checks++; if (rd !== old) begin n_fail++; $display("FAIL en_no_setup mem: got %h want %h", rd, old); end
      // Penable held high for a second cycle after the access phase
      @(posedge Pclk); @(negedge Pclk);
      n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd1 || rd_count !== m_rd) begin n_fail++; $display("FAIL en_held: got v=%b code=%0d rd=%0d want 1 1 %0d", err_valid, err_code, rd_count, m_rd); end
      idle(1, 3'b000);
   endtask

   task automatic test_phase_change();
      logic [31:0] rd, v20, v24; logic e1, e2, ee;
      v20 = $urandom | 32'd1; v24 = $urandom | 32'd1;
      xfer(BASE + 32'h20, 1'b1, v20, rd, e1, e2); model_xfer(BASE + 32'h20, 1'b1, v20, ee);
      xfer(BASE + 32'h24, 1'b1, v24, rd, e1, e2); model_xfer(BASE + 32'h24, 1'b1, v24, ee);
      Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h20; Pwdata = 32'hDEAD_BEEF;
      @(posedge Pclk); @(negedge Pclk);
      Penable = 1'b1; Paddr = BASE + 32'h24;
      @(posedge Pclk); @(negedge Pclk);
      m_code = 3'd3;
      n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd3) begin n_fail++; $display("FAIL phase_change: got v=%b code=%0d want 1 3", err_valid, err_code); end
      n_checks++; if (wr_count !== m_wr) begin n_fail++; $display("FAIL phase_change wr_count: got %0d want %0d", wr_count, m_wr); end
      idle(1, 3'b000);
      xfer(BASE + 32'h20, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + 32'h20, 1'b0, 32'd0, ee);
      n_checks++; if (rd !== v20) begin n_fail++; $display("FAIL phase_change mem20: got %h want %h", rd, v20); end
      xfer(BASE + 32'h24, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + 32'h24, 1'b0, 32'd0, ee);
      n_checks++; if (rd !== v24) begin n_fail++; $display("FAIL phase_change mem24: got %h want %h", rd, v24); end
   endtask

   task automatic test_bad_address();
      logic [31:0] rd, vlast; logic e1, e2, ee;
      xfer(BASE + SPAN, 1'b1, 32'h1234_5678, rd, e1, e2); model_xfer(BASE + SPAN, 1'b1, 32'h1234_5678, ee);
      n_checks++; if (e2 !== 1'b1 || err_code !== 3'd4 || wr_count !== m_wr) begin n_fail++; $display("FAIL out_of_range: got v=%b code=%0d wr=%0d want 1 4 %0d", e2, err_code, wr_count, m_wr); end
      xfer(BASE + 32'h2, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + 32'h2, 1'b0, 32'd0, ee);
      n_checks++; if (e2 !== 1'b1 || err_code !== 3'd5 || rd_count !== m_rd) begin n_fail++; $display("FAIL misaligned: got v=%b code=%0d rd=%0d want 1 5 %0d", e2, err_code, rd_count, m_rd); end
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL misaligned Prdata: got %h want 0", rd); end
      xfer(BASE - 32'd4, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE - 32'd4, 1'b0, 32'd0, ee);
      n_checks++; if (e2 !== 1'b1 || err_code !== 3'd4) begin n_fail++; $display("FAIL below_base: got v=%b code=%0d want 1 4", e2, err_code); end
      vlast = $urandom;
      xfer(BASE + SPAN - 32'd4, 1'b1, vlast, rd, e1, e2); model_xfer(BASE + SPAN - 32'd4, 1'b1, vlast, ee);
      xfer(BASE + SPAN - 32'd4, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + SPAN - 32'd4, 1'b0, 32'd0, ee);
      n_checks++; if (rd !== vlast || e2 !== 1'b0) begin n_fail++; $display("FAIL last_word: got %h err=%b want %h 0", rd, e2, vlast); end
      idle(1, 3'b000);
   endtask

   task automatic test_setup_stretch_abort();
      logic ee;
      Pselx = SEL; Penable = 1'b0; Pwrite = 1'b0; Paddr = BASE + 32'h10;
      @(posedge Pclk); @(negedge Pclk);
      Paddr = BASE + 32'h0;
      @(posedge Pclk); @(negedge Pclk);
      m_code = 3'd2;
      n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd2) begin n_fail++; $display("FAIL stretch: got v=%b code=%0d want 1 2", err_valid, err_code); end
      model_xfer(BASE + 32'h0, 1'b0, 32'd0, ee);
      Penable = 1'b1;
      @(posedge Pclk); @(negedge Pclk);
      n_checks++; if (err_valid !== 1'b0 || rd_count !== m_rd) begin n_fail++; $display("FAIL stretch complete: got v=%b rd=%0d want 0 %0d", err_valid, rd_count, m_rd); end
      Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h4; Pwdata = 32'hCAFE_F00D;
      @(posedge Pclk); @(negedge Pclk);
      Pselx = 3'b000;
      @(posedge Pclk); @(negedge Pclk);
      n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd2 || wr_count !== m_wr) begin n_fail++; $display("FAIL abort: got v=%b code=%0d wr=%0d want 1 2 %0d", err_valid, err_code, wr_count, m_wr); end
      Pselx = SEL; Penable = 1'b1;
      @(posedge Pclk); @(negedge Pclk);
      m_code = 3'd1;
      n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd1 || wr_count !== m_wr) begin n_fail++; $display("FAIL abort idle: got v=%b code=%0d wr=%0d want 1 1 %0d", err_valid, err_code, wr_count, m_wr); end
      idle(1, 3'b000);
   endtask

   task automatic test_preset_mid_write();
      logic [31:0] rd, old; logic e1, e2, ee;
      old = $urandom;
      xfer(BASE + 32'h30, 1'b1, old, rd, e1, e2); model_xfer(BASE + 32'h30, 1'b1, old, ee);
      idle(1, 3'b000);
      Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h30; Pwdata = ~old;
      @(posedge Pclk); @(negedge Pclk);
      Penable = 1'b1; Preset = 1'b1;
      @(posedge Pclk); @(negedge Pclk);
      Preset = 1'b0; Pselx = 3'b000; Penable = 1'b0;
      m_wr = 16'd0; m_rd = 16'd0; m_prdata = 32'd0; m_code = 3'd0;
      n_checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0 || err_code !== 3'd0 || Prdata !== 32'd0 || err_valid !== 1'b0)
         begin n_fail++; $display("FAIL preset state: got wr=%0d rd=%0d code=%0d prdata=%h v=%b want all 0", wr_count, rd_count, err_code, Prdata, err_valid); end
      Pselx = SEL; Penable = 1'b1;
      @(posedge Pclk); @(negedge Pclk);
      m_code = 3'd1;
      n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin n_fail++; $display("FAIL preset idle: got v=%b code=%0d want 1 1", err_valid, err_code); end
      idle(1, 3'b000);
      xfer(BASE + 32'h30, 1'b0, 32'd0, rd, e1, e2); model_xfer(BASE + 32'h30, 1'b0, 32'd0, ee);
      n_checks++; if (rd !== old || rd_count !== 16'd1 || wr_count !== 16'd0) begin n_fail++; $display("FAIL preset mem: got %h rd=%0d wr=%0d want %h 1 0", rd, rd_count, wr_count, old); end
      idle(1, 3'b000);
   endtask

   task automatic test_random();
      logic [31:0] rd, a, d; logic w, e1, e2, ee;
      logic [2:0] other [3];
      int kind;
      other[0] = 3'b000; other[1] = 3'b001; other[2] = 3'b100;
      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         xfer(BASE + 32'(4 * i), 1'b1, d, rd, e1, e2); model_xfer(BASE + 32'(4 * i), 1'b1, d, ee);
      end
      n_checks++; if (wr_count !== m_wr) begin n_fail++; $display("FAIL preload wr_count: got %0d want %0d", wr_count, m_wr); end
      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0) a = ($urandom_range(0, 1) == 1) ? BASE + SPAN + 32'(4 * $urandom_range(0, 3)) : BASE - 32'(4 * $urandom_range(1, 4));
         else if (kind == 1) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
         else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         xfer(a, w, d, rd, e1, e2); model_xfer(a, w, d, ee);
         if (!w) begin
            n_checks++; if (rd !== m_prdata) begin n_fail++; $display("FAIL rand %0d Prdata @%h: got %h want %h", n, a, rd, m_prdata); end
         end
         n_checks++; if (e1 !== 1'b0 || e2 !== ee) begin n_fail++; $display("FAIL rand %0d err_valid @%h: got %b%b want 0%b", n, a, e1, e2, ee); end
         n_checks++; if (err_code !== m_code) begin n_fail++; $display("FAIL rand %0d err_code: got %0d want %0d", n, err_code, m_code); end
         n_checks++; if (wr_count !== m_wr || rd_count !== m_rd) begin n_fail++; $display("FAIL rand %0d counts: got wr=%0d rd=%0d want %0d %0d", n, wr_count, rd_count, m_wr, m_rd); end
         if ($urandom_range(0, 2) != 0) begin
            idle(int'($urandom_range(1, 2)), other[$urandom_range(0, 2)]);
            n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rand %0d idle err_valid: got %b want 0", n, err_valid); end
         end
      end
      idle(1, 3'b000);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_enable_without_setup();
      test_phase_change();
      test_bad_address();
      test_setup_stretch_abort();
      test_preset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
